// File: rtl/axis_bf_pkg.sv
// Shared constants for the splitter: lane count, shift limit, saturation bound
// and the slot numbering used to map the eight output stages onto named ports.
package axis_bf_pkg;

    localparam int          SAMPLES         = 8;
    localparam int          SCALE_SHIFT_MAX = 3;
    localparam logic [15:0] SAT_POS         = 16'h7FFF;
    localparam int          N_SLOTS         = 8;

    typedef enum logic [2:0] {
        SLOT_M00_RE = 3'd0,
        SLOT_M00_IM = 3'd1,
        SLOT_M01_RE = 3'd2,
        SLOT_M01_IM = 3'd3,
        SLOT_M20_RE = 3'd4,
        SLOT_M20_IM = 3'd5,
        SLOT_M21_RE = 3'd6,
        SLOT_M21_IM = 3'd7
    } slot_e;

endpackage

// File: rtl/axis_fork_slot.sv
// One registered output stage of the splitter: loads on the shared accept and
// otherwise holds its beat until the downstream consumer takes it.
module axis_fork_slot #(
    parameter int DATA_W = 128,
    parameter int KEEP_W = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic [KEEP_W-1:0] o_tkeep,
    output logic              o_tlast,
    output logic              o_tvalid,
    output logic              o_free
);

    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_valid;

    // A load wins over a same-cycle drain so back-to-back beats leave no bubble.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (r_valid && i_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_tdata  = r_data;
    assign o_tlast  = r_last;
    assign o_tvalid = r_valid;
    assign o_tkeep  = r_valid ? '1 : '0;
    assign o_free   = !r_valid || i_tready;

endmodule

// File: rtl/axis_splitter.sv
// Scales each real/imag sample lane and forks the pair to four registered
// real/imag output streams that share a single lockstep input handshake.
module axis_splitter
    import axis_bf_pkg::*;
#(
    parameter int SDATA_WIDTH  = 128,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SCALE_SHIFT  = 2
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       s_axis_real_tvalid,
    output logic                       s_axis_real_tready,
    input  logic                       s_axis_real_tlast,
    input  logic [SDATA_WIDTH-1:0]     s_axis_real_tdata,
    input  logic                       s_axis_imag_tvalid,
    output logic                       s_axis_imag_tready,
    input  logic                       s_axis_imag_tlast,
    input  logic [SDATA_WIDTH-1:0]     s_axis_imag_tdata,

    output logic [SDATA_WIDTH-1:0]     m00_axis_real_tdata,
    output logic [SDATA_WIDTH/8-1:0]   m00_axis_real_tkeep,
    output logic                       m00_axis_real_tlast,
    output logic                       m00_axis_real_tvalid,
    input  logic                       m00_axis_real_tready,
    output logic [SDATA_WIDTH-1:0]     m00_axis_imag_tdata,
    output logic [SDATA_WIDTH/8-1:0]   m00_axis_imag_tkeep,
    output logic                       m00_axis_imag_tlast,
    output logic                       m00_axis_imag_tvalid,
    input  logic                       m00_axis_imag_tready,

    output logic [SDATA_WIDTH-1:0]     m01_axis_real_tdata,
    output logic [SDATA_WIDTH/8-1:0]   m01_axis_real_tkeep,
    output logic                       m01_axis_real_tlast,
    output logic                       m01_axis_real_tvalid,
    input  logic                       m01_axis_real_tready,
    output logic [SDATA_WIDTH-1:0]     m01_axis_imag_tdata,
    output logic [SDATA_WIDTH/8-1:0]   m01_axis_imag_tkeep,
    output logic                       m01_axis_imag_tlast,
    output logic                       m01_axis_imag_tvalid,
    input  logic                       m01_axis_imag_tready,

    output logic [SDATA_WIDTH-1:0]     m20_axis_real_tdata,
    output logic [SDATA_WIDTH/8-1:0]   m20_axis_real_tkeep,
    output logic                       m20_axis_real_tlast,
    output logic                       m20_axis_real_tvalid,
    input  logic                       m20_axis_real_tready,
    output logic [SDATA_WIDTH-1:0]     m20_axis_imag_tdata,
    output logic [SDATA_WIDTH/8-1:0]   m20_axis_imag_tkeep,
    output logic                       m20_axis_imag_tlast,
    output logic                       m20_axis_imag_tvalid,
    input  logic                       m20_axis_imag_tready,

    output logic [SDATA_WIDTH-1:0]     m21_axis_real_tdata,
    output logic [SDATA_WIDTH/8-1:0]   m21_axis_real_tkeep,
    output logic                       m21_axis_real_tlast,
    output logic                       m21_axis_real_tvalid,
    input  logic                       m21_axis_real_tready,
    output logic [SDATA_WIDTH-1:0]     m21_axis_imag_tdata,
    output logic [SDATA_WIDTH/8-1:0]   m21_axis_imag_tkeep,
    output logic                       m21_axis_imag_tlast,
    output logic                       m21_axis_imag_tvalid,
    input  logic                       m21_axis_imag_tready,

    output logic [15:0]                frame_count,
    output logic                       tlast_err
);

    localparam int KEEP_W    = SDATA_WIDTH / 8;
    localparam int SHIFT_EFF = (SCALE_SHIFT > SCALE_SHIFT_MAX) ? SCALE_SHIFT_MAX : SCALE_SHIFT;
    // Half an LSB of the shifted result; collapses to zero when nothing is shifted out.
    localparam int ROUND     = (1 << SHIFT_EFF) >> 1;

    function automatic logic [SAMPLE_WIDTH-1:0] scale_lane(input logic [SAMPLE_WIDTH-1:0] x);
        logic signed [SAMPLE_WIDTH:0] v;
        v = $signed({x[SAMPLE_WIDTH-1], x});
        v = v + (SAMPLE_WIDTH+1)'(ROUND);
        v = v >>> SHIFT_EFF;
        if (v > $signed({1'b0, SAT_POS})) begin
            return SAT_POS;
        end
        return v[SAMPLE_WIDTH-1:0];
    endfunction

    logic [SDATA_WIDTH-1:0] w_real_scaled;
    logic [SDATA_WIDTH-1:0] w_imag_scaled;

    for (genvar l = 0; l < SAMPLES; l++) begin : g_lane
        assign w_real_scaled[l*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
            scale_lane(s_axis_real_tdata[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
        assign w_imag_scaled[l*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
            scale_lane(s_axis_imag_tdata[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
    end

    logic [SDATA_WIDTH-1:0] w_tdata [N_SLOTS];
    logic [KEEP_W-1:0]      w_tkeep [N_SLOTS];
    logic [N_SLOTS-1:0]     w_tlast;
    logic [N_SLOTS-1:0]     w_tvalid;
    logic [N_SLOTS-1:0]     w_tready;
    logic [N_SLOTS-1:0]     w_free;
    logic                   w_can_accept;
    logic                   w_accept;
    logic                   w_out_last;
    logic [15:0]            r_frame_count;
    logic                   r_tlast_err;

    // Reset gates the handshake so nothing is taken while the slots are being cleared.
    assign w_can_accept       = (&w_free) && !reset;
    assign w_accept           = w_can_accept && s_axis_real_tvalid && s_axis_imag_tvalid;
    assign w_out_last         = s_axis_real_tlast || s_axis_imag_tlast;
    assign s_axis_real_tready = w_can_accept && s_axis_imag_tvalid;
    assign s_axis_imag_tready = w_can_accept && s_axis_real_tvalid;

    assign w_tready[SLOT_M00_RE] = m00_axis_real_tready;
    assign w_tready[SLOT_M00_IM] = m00_axis_imag_tready;
    assign w_tready[SLOT_M01_RE] = m01_axis_real_tready;
    assign w_tready[SLOT_M01_IM] = m01_axis_imag_tready;
    assign w_tready[SLOT_M20_RE] = m20_axis_real_tready;
    assign w_tready[SLOT_M20_IM] = m20_axis_imag_tready;
    assign w_tready[SLOT_M21_RE] = m21_axis_real_tready;
    assign w_tready[SLOT_M21_IM] = m21_axis_imag_tready;

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        axis_fork_slot #(
            .DATA_W (SDATA_WIDTH),
            .KEEP_W (KEEP_W)
        ) u_slot (
            .i_clock  (clock),
            .i_reset  (reset),
            .i_load   (w_accept),
            .i_data   ((k % 2 == 1) ? w_imag_scaled : w_real_scaled),
            .i_last   (w_out_last),
            .i_tready (w_tready[k]),
            .o_tdata  (w_tdata[k]),
            .o_tkeep  (w_tkeep[k]),
            .o_tlast  (w_tlast[k]),
            .o_tvalid (w_tvalid[k]),
            .o_free   (w_free[k])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_count <= '0;
            r_tlast_err   <= 1'b0;
        end else if (w_accept) begin
            if (w_out_last) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (s_axis_real_tlast != s_axis_imag_tlast) begin
                r_tlast_err <= 1'b1;
            end
        end
    end

    assign frame_count = r_frame_count;
    assign tlast_err   = r_tlast_err;

    assign m00_axis_real_tdata  = w_tdata[SLOT_M00_RE];
    assign m00_axis_real_tkeep  = w_tkeep[SLOT_M00_RE];
    assign m00_axis_real_tlast  = w_tlast[SLOT_M00_RE];
    assign m00_axis_real_tvalid = w_tvalid[SLOT_M00_RE];
    assign m00_axis_imag_tdata  = w_tdata[SLOT_M00_IM];
    assign m00_axis_imag_tkeep  = w_tkeep[SLOT_M00_IM];
    assign m00_axis_imag_tlast  = w_tlast[SLOT_M00_IM];
    assign m00_axis_imag_tvalid = w_tvalid[SLOT_M00_IM];

    assign m01_axis_real_tdata  = w_tdata[SLOT_M01_RE];
    assign m01_axis_real_tkeep  = w_tkeep[SLOT_M01_RE];
    assign m01_axis_real_tlast  = w_tlast[SLOT_M01_RE];
    assign m01_axis_real_tvalid = w_tvalid[SLOT_M01_RE];
    assign m01_axis_imag_tdata  = w_tdata[SLOT_M01_IM];
    assign m01_axis_imag_tkeep  = w_tkeep[SLOT_M01_IM];
    assign m01_axis_imag_tlast  = w_tlast[SLOT_M01_IM];
    assign m01_axis_imag_tvalid = w_tvalid[SLOT_M01_IM];

    assign m20_axis_real_tdata  = w_tdata[SLOT_M20_RE];
    assign m20_axis_real_tkeep  = w_tkeep[SLOT_M20_RE];
    assign m20_axis_real_tlast  = w_tlast[SLOT_M20_RE];
    assign m20_axis_real_tvalid = w_tvalid[SLOT_M20_RE];
    assign m20_axis_imag_tdata  = w_tdata[SLOT_M20_IM];
    assign m20_axis_imag_tkeep  = w_tkeep[SLOT_M20_IM];
    assign m20_axis_imag_tlast  = w_tlast[SLOT_M20_IM];
    assign m20_axis_imag_tvalid = w_tvalid[SLOT_M20_IM];

    assign m21_axis_real_tdata  = w_tdata[SLOT_M21_RE];
    assign m21_axis_real_tkeep  = w_tkeep[SLOT_M21_RE];
    assign m21_axis_real_tlast  = w_tlast[SLOT_M21_RE];
    assign m21_axis_real_tvalid = w_tvalid[SLOT_M21_RE];
    assign m21_axis_imag_tdata  = w_tdata[SLOT_M21_IM];
    assign m21_axis_imag_tkeep  = w_tkeep[SLOT_M21_IM];
    assign m21_axis_imag_tlast  = w_tlast[SLOT_M21_IM];
    assign m21_axis_imag_tvalid = w_tvalid[SLOT_M21_IM];

endmodule

// File: tb/tb_axis_splitter.sv
// Bench for axis_splitter: instance g uses SCALE_SHIFT=g; instance 2 is fully
// scoreboarded, instances 0 and 1 run with free outputs for scaling checks.
module tb_axis_splitter;

    localparam int DW = 128;
    localparam int SW = 16;
    localparam int KW = DW / 8;
    localparam int NI = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          s_rvalid = 1'b0, s_ivalid = 1'b0, s_rlast = 1'b0, s_ilast = 1'b0;
    logic [DW-1:0] s_rdata = '0, s_idata = '0;
    logic          s_rrdy [NI];
    logic          s_irdy [NI];
    logic [DW-1:0] m_data  [NI][8];
    logic [KW-1:0] m_keep  [NI][8];
    logic          m_last  [NI][8];
    logic          m_valid [NI][8];
    logic          m_rdy   [8];
    logic [15:0]   fcnt    [NI];
    logic          terr    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        axis_splitter #(.SDATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .SCALE_SHIFT(g)) dut (
            .clock(clock), .reset(reset),
            .s_axis_real_tvalid(s_rvalid), .s_axis_real_tready(s_rrdy[g]),
            .s_axis_real_tlast(s_rlast), .s_axis_real_tdata(s_rdata),
            .s_axis_imag_tvalid(s_ivalid), .s_axis_imag_tready(s_irdy[g]),
            .s_axis_imag_tlast(s_ilast), .s_axis_imag_tdata(s_idata),
            .m00_axis_real_tdata(m_data[g][0]), .m00_axis_real_tkeep(m_keep[g][0]),
            .m00_axis_real_tlast(m_last[g][0]), .m00_axis_real_tvalid(m_valid[g][0]),
            .m00_axis_real_tready(g == 2 ? m_rdy[0] : 1'b1),
            .m00_axis_imag_tdata(m_data[g][1]), .m00_axis_imag_tkeep(m_keep[g][1]),
            .m00_axis_imag_tlast(m_last[g][1]), .m00_axis_imag_tvalid(m_valid[g][1]),
            .m00_axis_imag_tready(g == 2 ? m_rdy[1] : 1'b1),
            .m01_axis_real_tdata(m_data[g][2]), .m01_axis_real_tkeep(m_keep[g][2]),
            .m01_axis_real_tlast(m_last[g][2]), .m01_axis_real_tvalid(m_valid[g][2]),
            .m01_axis_real_tready(g == 2 ? m_rdy[2] : 1'b1),
            .m01_axis_imag_tdata(m_data[g][3]), .m01_axis_imag_tkeep(m_keep[g][3]),
            .m01_axis_imag_tlast(m_last[g][3]), .m01_axis_imag_tvalid(m_valid[g][3]),
            .m01_axis_imag_tready(g == 2 ? m_rdy[3] : 1'b1),
            .m20_axis_real_tdata(m_data[g][4]), .m20_axis_real_tkeep(m_keep[g][4]),
            .m20_axis_real_tlast(m_last[g][4]), .m20_axis_real_tvalid(m_valid[g][4]),
            .m20_axis_real_tready(g == 2 ? m_rdy[4] : 1'b1),
            .m20_axis_imag_tdata(m_data[g][5]), .m20_axis_imag_tkeep(m_keep[g][5]),
            .m20_axis_imag_tlast(m_last[g][5]), .m20_axis_imag_tvalid(m_valid[g][5]),
            .m20_axis_imag_tready(g == 2 ? m_rdy[5] : 1'b1),
            .m21_axis_real_tdata(m_data[g][6]), .m21_axis_real_tkeep(m_keep[g][6]),
            .m21_axis_real_tlast(m_last[g][6]), .m21_axis_real_tvalid(m_valid[g][6]),
            .m21_axis_real_tready(g == 2 ? m_rdy[6] : 1'b1),
            .m21_axis_imag_tdata(m_data[g][7]), .m21_axis_imag_tkeep(m_keep[g][7]),
            .m21_axis_imag_tlast(m_last[g][7]), .m21_axis_imag_tvalid(m_valid[g][7]),
            .m21_axis_imag_tready(g == 2 ? m_rdy[7] : 1'b1),
            .frame_count(fcnt[g]), .tlast_err(terr[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] scale_ref(input logic [15:0] x, input int sh);
        int v;
        v = int'($signed(x));
        if (sh > 0) v = v + (1 << (sh - 1));
        v = v >>> sh;
        if (v > 32767) v = 32767;
        return 16'(v);
    endfunction

    function automatic logic [DW-1:0] exp_scale(input logic [DW-1:0] x, input int sh);
        logic [DW-1:0] r;
        for (int l = 0; l < 8; l++) r[l*16 +: 16] = scale_ref(x[l*16 +: 16], sh);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Scoreboard for instance 2: one expected beat per accept, consumed per output.
    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    cons [8];

    always @(negedge clock) begin : mon
        beat_t b;
        bit    all_used;
        if (!reset) begin
            for (int k = 0; k < 8; k++) begin
                if (m_valid[2][k] && m_rdy[k]) begin
                    check($sformatf("sb_avail%0d", k), DW'(cons[k] < exp_q.size()), 1);
                    if (cons[k] < exp_q.size()) begin
                        b = exp_q[cons[k]];
                        check($sformatf("sb_data%0d", k), m_data[2][k], (k % 2 == 1) ? b.im : b.re);
                        check($sformatf("sb_last%0d", k), m_last[2][k], b.last);
                        check($sformatf("sb_keep%0d", k), m_keep[2][k], 16'hFFFF);
                        cons[k]++;
                    end
                end
            end
            while (exp_q.size() > 0) begin
                all_used = 1'b1;
                for (int k = 0; k < 8; k++) if (cons[k] == 0) all_used = 1'b0;
                if (!all_used) break;
                void'(exp_q.pop_front());
                for (int k = 0; k < 8; k++) cons[k]--;
            end
            if (s_rvalid && s_rrdy[2] && s_ivalid && s_irdy[2]) begin
                b.re   = exp_scale(s_rdata, 2);
                b.im   = exp_scale(s_idata, 2);
                b.last = s_rlast | s_ilast;
                exp_q.push_back(b);
            end
        end
    end

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input logic rl, input logic il, output int ncyc);
        bit ok;
        s_rdata = re; s_idata = im; s_rlast = rl; s_ilast = il;
        s_rvalid = 1'b1; s_ivalid = 1'b1;
        ok = 1'b0;
        ncyc = 0;
        while (!ok && ncyc < 50) begin
            @(negedge clock);
            ok = s_rrdy[2] && s_irdy[2];
            @(posedge clock); #1;
            ncyc++;
        end
        check("send_accept", DW'(ok), 1);
    endtask

    task automatic idle();
        s_rvalid = 1'b0; s_ivalid = 1'b0; s_rlast = 1'b0; s_ilast = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 8; k++) cons[k] = 0;
        @(posedge clock); #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ncyc, bubbles;
        logic [15:0]   fc0;
        logic [DW-1:0] re, im, held;

        for (int k = 0; k < 8; k++) begin m_rdy[k] = 1'b1; cons[k] = 0; end
        // Inputs valid during reset must not be taken.
        s_rvalid = 1'b1; s_ivalid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rrdy", s_rrdy[2], 0);
        check("rst_irdy", s_irdy[2], 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rst_valid%0d", k), m_valid[2][k], 0);
            check($sformatf("rst_keep%0d", k), m_keep[2][k], 0);
            check($sformatf("rst_data%0d", k), m_data[2][k], 0);
        end
        check("rst_fcnt", fcnt[2], 0);
        check("rst_terr", terr[2], 0);

        // First beat offered the same cycle reset drops.
        reset = 1'b0;
        send({8{16'h0100}}, {8{16'hFF00}}, 1'b0, 1'b0, ncyc);
        idle();
        check("first_accept_cyc", ncyc, 1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("basic_valid%0d", k), m_valid[2][k], 1);
            check($sformatf("basic_data%0d", k), m_data[2][k],
                  (k % 2 == 1) ? {8{16'hFFC0}} : {8{16'h0040}});
            check($sformatf("basic_keep%0d", k), m_keep[2][k], 16'hFFFF);
        end
        @(posedge clock); #1;
        check("drain_valid", m_valid[2][0], 0);

        // Extremes across shifts 0 and 1, then random lanes against the model.
        send({8{16'h7FFF}}, {8{16'h8000}}, 1'b0, 1'b0, ncyc);
        check("sh0_max", m_data[0][0], {8{16'h7FFF}});
        check("sh0_min", m_data[0][1], {8{16'h8000}});
        check("sh1_max", m_data[1][0], {8{16'h4000}});
        check("sh1_min", m_data[1][1], {8{16'hC000}});
        for (int i = 0; i < 6; i++) begin
            re = rand_vec(); im = rand_vec();
            send(re, im, 1'b0, 1'b0, ncyc);
            for (int g = 0; g < 2; g++) begin
                check($sformatf("rnd_re_sh%0d", g), m_data[g][0], exp_scale(re, g));
                check($sformatf("rnd_im_sh%0d", g), m_data[g][7], exp_scale(im, g));
            end
        end
        idle();
        repeat (2) @(posedge clock);
        #1;

        // Stall m20 imag for five cycles during a four-beat stream.
        fork
            begin
                for (int b = 0; b < 4; b++) send(rand_vec(), rand_vec(), b == 3, b == 3, ncyc);
                idle();
            end
            begin
                @(posedge clock); #1;
                m_rdy[5] = 1'b0;
                held = m_data[2][5];
                for (int i = 0; i < 5; i++) begin
                    @(negedge clock);
                    check("stall_slot_valid", m_valid[2][5], 1);
                    check("stall_rrdy", s_rrdy[2], 0);
                    check("stall_hold", m_data[2][5], held);
                    if (i >= 1) check("stall_other_empty", m_valid[2][0], 0);
                end
                @(posedge clock); #1;
                m_rdy[5] = 1'b1;
            end
        join
        repeat (3) @(posedge clock);
        #1;
        check("stall_sb_drain", exp_q.size(), 0);

        // Real valid without imag valid must never be accepted.
        s_rvalid = 1'b1; s_rdata = rand_vec();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("halfvalid_rrdy", s_rrdy[2], 0);
            check("halfvalid_slot", m_valid[2][0], 0);
        end
        idle();
        @(posedge clock); #1;
        check("halfvalid_after", m_valid[2][3], 0);

        // Mismatched tlast marks the frame end and sets the sticky error.
        fc0 = fcnt[2];
        send(rand_vec(), rand_vec(), 1'b1, 1'b0, ncyc);
        idle();
        check("tlerr_set", terr[2], 1);
        check("tlerr_fcnt", fcnt[2], fc0 + 16'd1);
        send(rand_vec(), rand_vec(), 1'b0, 1'b0, ncyc);
        idle();
        check("tlerr_sticky", terr[2], 1);
        check("tlerr_fcnt_hold", fcnt[2], fc0 + 16'd1);

        // Reset with a beat parked in every slot discards it.
        @(posedge clock); #1;
        for (int k = 0; k < 8; k++) m_rdy[k] = 1'b0;
        send(rand_vec(), rand_vec(), 1'b0, 1'b0, ncyc);
        idle();
        @(posedge clock); #1;
        check("park_valid", m_valid[2][3], 1);
        do_reset();
        for (int k = 0; k < 8; k++) check($sformatf("mid_rst_valid%0d", k), m_valid[2][k], 0);
        check("mid_rst_terr", terr[2], 0);
        check("mid_rst_fcnt", fcnt[2], 0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) m_rdy[k] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("post_rst_quiet", m_valid[2][6], 0);
        end
        @(posedge clock); #1;

        // 65536 single-beat frames back to back: counter wraps, no bubbles.
        bubbles = 0;
        for (int i = 0; i < 65536; i++) begin
            send(rand_vec(), rand_vec(), 1'b1, 1'b1, ncyc);
            if (ncyc != 1) bubbles++;
            if (i == 65534) check("wrap_ffff", fcnt[2], 16'hFFFF);
        end
        idle();
        check("wrap_zero", fcnt[2], 16'h0000);
        check("no_bubble", bubbles, 0);
        check("wrap_terr", terr[2], 0);
        repeat (3) @(posedge clock);
        #1;
        check("final_sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_splitter.md
AXIS_SPLITTER -- requirements
Module: axis_splitter

Interface
REQ-001 SHALL have parameter SDATA_WIDTH, default 128, meaning the tdata width of every stream.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16, meaning the signed two's-complement sample width (SAMPLES = SDATA_WIDTH/SAMPLE_WIDTH = 8).
REQ-003 SHALL have parameter SCALE_SHIFT, default 2, range 0..3, meaning the per-sample arithmetic right shift applied before fan-out.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports s_axis_real_tvalid/tready/tlast (in/out/in, 1 bit each) and s_axis_real_tdata (in, SDATA_WIDTH): the real input stream.
REQ-007 SHALL have ports s_axis_imag_tvalid/tready/tlast/tdata, with the same directions and widths: the imaginary input stream.
REQ-008 SHALL have, for each XX in {00,01,20,21} and P in {real,imag}, ports mXX_axis_P_tdata (out, SDATA_WIDTH), mXX_axis_P_tkeep (out, SDATA_WIDTH/8), mXX_axis_P_tlast (out, 1), mXX_axis_P_tvalid (out, 1) and mXX_axis_P_tready (in, 1).
REQ-009 SHALL have port frame_count, output, 16 bits: the number of input beats accepted with tlast, wrapping.
REQ-010 SHALL have port tlast_err, output, 1 bit: a sticky flag set on a real/imag tlast mismatch.

Function
REQ-011 SHALL hold one output register slot per output stream (8 slots), each with its own valid flag.
REQ-012 SHALL compute can_accept = AND over all 8 slots of (!slot_valid OR slot_tready).
REQ-013 SHALL drive s_axis_real_tready = can_accept AND s_axis_imag_tvalid, and s_axis_imag_tready = can_accept AND s_axis_real_tvalid, so the two streams are always accepted in the same cycle.
REQ-014 SHALL define an accept as can_accept AND both input tvalid high. On an accept, all 8 slots load in the same cycle and their valid flags go to 1; output latency is exactly 1 cycle.
REQ-015 SHALL clear a slot's valid flag when that slot handshakes (valid AND tready) and no accept occurs that cycle.
REQ-016 SHALL, when a slot handshakes in the same cycle as an accept, reload the slot with the new data and keep valid = 1 (no bubble).
REQ-017 SHALL hold a slot's tdata, tlast and tkeep stable while valid = 1 and tready = 0.
REQ-018 SHALL, when any slot stalls, block further accepts; slots that already drained stay empty until the next accept.
REQ-019 SHALL compute each output sample (per lane i, real and imag independently) as (x + 2^(SCALE_SHIFT-1)) >>> SCALE_SHIFT, evaluated at SAMPLE_WIDTH+1 bits.
REQ-020 SHALL saturate the REQ-019 result to the maximum positive value (0x7FFF) if it exceeds that value, and SHALL apply no rounding term when SCALE_SHIFT = 0.
REQ-021 SHALL load identical real data into all four real slots and identical imag data into all four imag slots.
REQ-022 SHALL drive every slot's tkeep as all ones whenever that slot is valid, and as 0 otherwise.
REQ-023 SHALL drive the slot tlast on an accept as s_axis_real_tlast OR s_axis_imag_tlast.
REQ-024 SHALL, on an accept where the real and imag tlast differ, set tlast_err to 1; tlast_err clears only on reset.
REQ-025 SHALL increment frame_count on an accept whose output tlast is 1, wrapping from 0xFFFF to 0x0000.

Reset
REQ-026 SHALL, when reset is high at a clock edge, clear all slot valid, tdata, tkeep and tlast to 0, set frame_count = 0 and tlast_err = 0, and make both s tready signals 0 on the following cycle.
REQ-027 SHALL, on reset mid-transfer, discard any pending slot data with no partial output, and SHALL allow the first accept on the first cycle after reset deasserts.

Structure
REQ-028 SHALL place SAMPLES, the SCALE_SHIFT range limit and the saturation constants in a shared package, axis_bf_pkg.
REQ-029 SHALL implement one sub-module, axis_fork_slot, instantiated 8 times; it holds the slot register, valid flag and the REQ-015/016/017 handshake logic.
REQ-030 SHALL implement the scaling of REQ-019/020 as a per-lane function shared by the real and imag paths.

Verification
REQ-031 SHALL cover: SCALE_SHIFT=2, all lanes real=0x0100, imag=0xFF00, both valid, all tready=1 -> cycle+1: all real outputs 0x0040, all imag outputs 0xFFC0, tkeep=0xFFFF.
REQ-032 SHALL cover: lane value 0x7FFF with SCALE_SHIFT=0 -> 0x7FFF; with SCALE_SHIFT=1 -> 0x4000; lane value 0x8000 with SCALE_SHIFT=1 -> 0xC000.
REQ-033 SHALL cover: m20_axis_imag_tready held 0 for 5 cycles during a 4-beat stream -> s tready low for those cycles, m20 imag data stable, no beat lost or duplicated on any output.
REQ-034 SHALL cover: real tvalid=1 with imag tvalid=0 for 3 cycles -> no accept, s_axis_real_tready=0, and no slot valid rises.
REQ-035 SHALL cover: beats with real tlast=1 and imag tlast=0 -> all outputs show tlast=1, tlast_err=1, frame_count increments by 1; a later reset -> tlast_err=0 and frame_count=0.
REQ-036 SHALL cover: 65536 single-beat frames -> frame_count wraps to 0x0000; continuous tready=1 -> one accept every cycle with no bubbles.
